// File: rtl/xm_uart_rx_pkg.sv
// Definitions shared by the UART receiver and transmitter: FSM states, baud divider table
// and line levels.
package xm_uart_rx_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

    localparam int unsigned DIV_W = 9;

    // Divider terminal count per baud_set; one sample tick every DR+1 clocks at 50 MHz.
    localparam logic [DIV_W-1:0] DR_9600   = 9'd324;
    localparam logic [DIV_W-1:0] DR_19200  = 9'd162;
    localparam logic [DIV_W-1:0] DR_38400  = 9'd80;
    localparam logic [DIV_W-1:0] DR_57600  = 9'd53;
    localparam logic [DIV_W-1:0] DR_115200 = 9'd26;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Sub-sample indices of the mid-bit majority vote.
    localparam int unsigned SAMP_FIRST = 7;
    localparam int unsigned SAMP_MID   = 8;
    localparam int unsigned SAMP_LAST  = 9;

    function automatic logic [DIV_W-1:0] baud_dr(input logic [2:0] baud_set);
        logic [DIV_W-1:0] dr;
        case (baud_set)
            3'd1:    dr = DR_19200;
            3'd2:    dr = DR_38400;
            3'd3:    dr = DR_57600;
            3'd4:    dr = DR_115200;
            default: dr = DR_9600;
        endcase
        return dr;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/xm_uart_rx_if.sv
// Line-side and user-side signals of the UART receiver; master drives the line and baud select.
interface xm_uart_rx_if;

    logic [2:0] baud_set;
    logic       rs232_rx;
    logic [7:0] data_byte;
    logic       rx_done;
    logic       frame_err;
    logic       uart_state;

    modport master (
        output baud_set,
        output rs232_rx,
        input  data_byte,
        input  rx_done,
        input  frame_err,
        input  uart_state
    );

    modport slave (
        input  baud_set,
        input  rs232_rx,
        output data_byte,
        output rx_done,
        output frame_err,
        output uart_state
    );

endinterface

// File: rtl/xm_uart_baud_tick.sv
// 16x oversampling tick generator; the divider is latched at frame start so baud changes
// mid-frame have no effect.
module xm_uart_baud_tick
    import xm_uart_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i_baud_set,
    input  logic       i_start,
    input  logic       i_run,
    output logic       o_samp_tick
);

    logic [DIV_W-1:0] r_dr;
    logic [DIV_W-1:0] r_div_cnt;
    logic             w_wrap;

    assign w_wrap      = (r_div_cnt == r_dr);
    assign o_samp_tick = i_run && w_wrap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dr      <= DR_9600;
            r_div_cnt <= '0;
        end else begin
            if (i_start) begin
                r_dr <= baud_dr(i_baud_set);
            end
            if (!i_run || i_start || w_wrap) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/xm_uart_rx.sv
// 8N1 UART receiver: input synchronizer, falling-edge start detect, 3-sample mid-bit vote,
// false-start rejection and framing-error flag.
module xm_uart_rx
    import xm_uart_rx_pkg::*;
#(
    parameter int unsigned OSR         = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic          clk,
    input logic          rst,
    xm_uart_rx_if.slave  rx_if
);

    localparam int unsigned SUB_W = $clog2(OSR);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_prev;
    uart_state_e            r_state;
    logic [SUB_W-1:0]       r_sub_cnt;
    logic [2:0]             r_bit_cnt;
    logic [1:0]             r_samp;
    logic [7:0]             r_shift;
    logic [7:0]             r_data_byte;
    logic                   r_rx_done;
    logic                   r_frame_err;
    logic                   r_uart_state;

    logic w_rx;
    logic w_start_edge;
    logic w_samp_tick;
    logic w_vote;
    logic w_at_vote;
    logic w_at_wrap;

    assign w_rx         = r_sync[SYNC_STAGES-1];
    assign w_start_edge = (r_state == StIdle) && r_rx_prev && !w_rx;
    assign w_vote       = maj3(r_samp[0], r_samp[1], w_rx);
    assign w_at_vote    = w_samp_tick && (r_sub_cnt == SUB_W'(SAMP_LAST));
    assign w_at_wrap    = w_samp_tick && (r_sub_cnt == SUB_W'(OSR - 1));

    xm_uart_baud_tick u_baud_tick (
        .clk         (clk),
        .rst         (rst),
        .i_baud_set  (rx_if.baud_set),
        .i_start     (w_start_edge),
        .i_run       (r_uart_state),
        .o_samp_tick (w_samp_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync       <= '1;
            r_rx_prev    <= 1'b1;
            r_state      <= StIdle;
            r_sub_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_samp       <= '0;
            r_shift      <= '0;
            r_data_byte  <= '0;
            r_rx_done    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_uart_state <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], rx_if.rs232_rx};
            r_rx_prev   <= w_rx;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;

            if (w_samp_tick) begin
                r_sub_cnt <= w_at_wrap ? '0 : r_sub_cnt + 1'b1;
                if (r_sub_cnt == SUB_W'(SAMP_FIRST)) r_samp[0] <= w_rx;
                if (r_sub_cnt == SUB_W'(SAMP_MID))   r_samp[1] <= w_rx;
            end

            case (r_state)
                StIdle: begin
                    if (w_start_edge) begin
                        r_state      <= StStart;
                        r_uart_state <= 1'b1;
                        r_sub_cnt    <= '0;
                    end
                end
                StStart: begin
                    if (w_at_vote && (w_vote != START_BIT)) begin
                        r_state      <= StIdle;
                        r_uart_state <= 1'b0;
                    end else if (w_at_wrap) begin
                        r_state   <= StData;
                        r_bit_cnt <= '0;
                    end
                end
                StData: begin
                    // Right shift: the first (LSB) bit ends up in r_shift[0].
                    if (w_at_vote) begin
                        r_shift <= {w_vote, r_shift[7:1]};
                    end
                    if (w_at_wrap) begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= StStop;
                        end
                    end
                end
                StStop: begin
                    // Leave at mid-stop so a back-to-back start edge is still seen in idle.
                    if (w_at_vote) begin
                        if (w_vote == STOP_BIT) begin
                            r_data_byte <= r_shift;
                            r_rx_done   <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                        r_state      <= StIdle;
                        r_uart_state <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= StIdle;
                    r_uart_state <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.data_byte  = r_data_byte;
    assign rx_if.rx_done    = r_rx_done;
    assign rx_if.frame_err  = r_frame_err;
    assign rx_if.uart_state = r_uart_state;

endmodule

// File: doc/xm_uart_rx.md
Name: xm_uart_rx

Overview:
- UART receiver, 8N1 frame (1 start, 8 data LSB-first, 1 stop).
- Counterpart to the team's xm_uart_tx; uses the same baud_set encoding.
- Sits between the board RX pin and the user logic.
- Oversamples 16x per bit, takes a 3-sample majority vote mid-bit, rejects false starts, flags framing errors.

Parameters:
- OSR, 16, samples per bit; fixed, the sub-sample indices below assume 16.
- SYNC_STAGES, 2, flip-flop stages on the asynchronous rs232_rx input.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous, active-low reset.
- baud_set  input  3  baud select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, others=9600.
- rs232_rx  input  1  serial line, asynchronous, idle high.
- data_byte  output  8  last correctly received byte.
- rx_done  output  1  one-cycle pulse when a good frame completes.
- frame_err  output  1  one-cycle pulse when the stop bit samples low.
- uart_state  output  1  high while a frame is being received.

Behaviour:
- Reset values: data_byte=0, rx_done=0, frame_err=0, uart_state=0, state=IDLE. Synchronizer flops reset to 1.
- Reset is asynchronous; asserting it mid-frame aborts the frame with no rx_done and no frame_err.
- Divider value DR per baud_set: 0→324, 1→162, 2→80, 3→53, 4→26, default→324.
  - DR is latched when a start is detected; baud_set changes mid-frame are ignored.
- Tick generator:
  - div_cnt counts 0..DR, then wraps; one-cycle samp_tick on the wrap.
  - Runs only while uart_state=1; held at 0 otherwise.
- sub_cnt (4 bits) counts ticks 0..15 within a bit and wraps to 0 at the bit boundary.
- Edge detect: a falling edge on the synchronized rx (previous 1, current 0) while in IDLE starts a frame.
  - Edge to uart_state=1 is 1 cycle.
  - Effective latency from the pin is SYNC_STAGES+1 cycles.
- Majority vote: register the synchronized rx on sub_cnt=7, 8 and 9; bit value = majority of the 3 samples.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: wait for a falling edge → START. Clear div_cnt and sub_cnt; uart_state=1.
  - START: at sub_cnt=9 (after the 3rd sample), evaluate the vote.
    - Majority 1 → false start: go to IDLE, uart_state=0, no pulses.
    - Majority 0 → continue; at sub_cnt wrap → DATA with bit_cnt=0.
  - DATA: at sub_cnt=9, shift the vote into shift_reg[7] (right shift, so LSB arrives first).
    - At sub_cnt wrap, bit_cnt increments.
    - When bit_cnt=7 wraps → STOP.
  - STOP: at sub_cnt=9, evaluate the vote.
    - Majority 1 → data_byte<=shift_reg and rx_done=1 on the next cycle.
    - Majority 0 → frame_err=1 for 1 cycle; data_byte is unchanged.
    - Either way: go to IDLE and set uart_state=0 in the same cycle as the pulse.
  - Leaving at mid-stop lets a back-to-back start edge be caught with no lost frame.
- rx_done and frame_err are mutually exclusive, exactly 1 cycle wide, and never asserted outside a STOP exit.
- A line stuck low after a frame error produces no new frame until rx returns high and falls again (edge-triggered).
- data_byte is stable between rx_done pulses.

Decomposition:
- Shared package/include (shared with xm_uart_tx): FSM state encodings, the baud divider constant table (DR per baud_set) as localparams, and START_BIT/STOP_BIT values.
- One natural sub-module: xm_uart_baud_tick (DR select/latch, div_cnt, samp_tick). The synchronizer, FSM and shifter stay in xm_uart_rx.

Test Plan:
- baud_set=4, send 0xA5 at 434 clk/bit → one rx_done pulse, data_byte=0xA5, frame_err=0, uart_state falls with rx_done.
- baud_set=4, drive a 100-cycle low glitch on idle rs232_rx → uart_state pulses high, then returns 0 by tick 9; no rx_done, data_byte unchanged.
- baud_set=4, send 0x3C with stop bit=0 → frame_err one-cycle pulse, rx_done=0, data_byte keeps its previous value (0xA5).
- baud_set=4, send 0x00 then 0xFF back-to-back with a 1-bit stop and no idle gap → two rx_done pulses, data_byte 0x00 then 0xFF.
- baud_set=0 (5208 clk/bit), send 0x55 with ±2% bit-time skew → data_byte=0x55, rx_done=1. Change baud_set to 4 mid-frame → reception is still correct at 9600.
- Assert rst low during data bit 4 of a frame → all outputs 0 immediately. After release, the next clean frame 0x81 → data_byte=0x81.
